stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Minutes:seconds stopwatch datapath that consumes the divided clock levels produced by the team's clock divider and produces four BCD digits for the display multiplexer. It edge-detects the 1 Hz count level and the 2 Hz adjust level inside the single system clock domain. It counts 00:00 to 59:59 with wrap-around, supports pause, and supports a per-field adjust mode. It sits directly downstream of the clock divider and upstream of the seven-segment display driver.

## Interface
- No parameters. The rollover limits are constants in the shared package.
- clk  in  1  System clock, the same 100 MHz clock that drives the divider.
- rst  in  1  Asynchronous, active-low reset. Asserted when 0.
- counter_clk  in  1  1 Hz divider output level. Counting uses its rising edges.
- adj_clk  in  1  2 Hz divider output level. Adjust uses its rising edges.
- pause  in  1  Debounced button level. Each rising edge toggles the paused state.
- adj  in  1  Level input. 1 selects adjust mode.
- sel  in  1  Adjust field select. 0 selects minutes, 1 selects seconds.
- lap  in  1  Debounced button level. Present only when STOPWATCH_LAP_EN is defined.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits, each in the range 0..9.
- running  out  1  1 when not paused.

## Operation
- **Edge detection**
  - One history register each for counter_clk, adj_clk and pause (plus lap when enabled).
  - A tick is `cur & ~prev`.
  - The counter_clk and adj_clk history registers reset to 1. The divider powers up with these levels high, so no tick can occur in the cycle after reset.
  - The pause and lap history registers reset to 0.
- **State**
  - Two BCD pairs, min and sec, each holding 00..59.
  - paused flag.
  - Reset values: all digits 0, paused=0, so running=1.
- **Count mode (adj=0)**
  - On a count tick with paused=0, sec increments.
  - sec=59 rolls to 00 and carries into min.
  - 59:59 wraps to 00:00.
  - adj ticks are ignored.
- **Adjust mode (adj=1)**
  - Count ticks are ignored.
  - On each adj tick, only the field chosen by sel increments, with 59→00 and no carry.
  - Adjust ignores paused, so adjust works while paused.
  - sel and adj are sampled in the same cycle as the tick.
- **Digit arithmetic**
  - Ones digit: 9→0 with carry into tens.
  - Tens digit: 5→0, and only when ones=9.
  - Digits never leave 0..9 or 0..5.
- **Pause**
  - A pause tick toggles paused.
  - If a pause tick and a count tick arrive in the same cycle, the count uses the pre-toggle paused value. A running watch therefore counts that tick and then stops.
- **Reset mid-operation** clears state immediately and asynchronously. The first count tick occurs on the next genuine rising edge of counter_clk.

## Timing
- An input rising edge sampled at clk edge N produces updated digits after clk edge N+1, giving 1-cycle latency.
- running follows the same latency.
- Each level edge produces exactly one tick, independent of how long the level stays high.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- **STOPWATCH_LAP_EN defined:**
  - Adds the lap input and a lap_hold flag, reset value 0.
  - A lap tick toggles lap_hold.
  - While lap_hold=1, the output digits stay frozen at the count captured on the toggle cycle, while the internal count keeps running.
  - Clearing lap_hold shows the live count after the usual 1-cycle latency.
- **Undefined:** no lap port, and the outputs always show the live count.

## Structure
- **Shared package `stopwatch_pkg`** holds:
  - The bcd_pair type (two 4-bit digits).
  - The constants SEC_MAX=59 and MIN_MAX=59.
  - Reset constants for the digits.
- **Sub-module `bcd_mod60_inc`** is combinational.
  - Inputs: a BCD pair and an enable.
  - Outputs: the next pair and a carry, where carry=1 only on 59→00 with enable=1.
  - It is instantiated once for sec and once for min.

## Test plan
- **Reset and count:** release rst, then apply 3 counter_clk rising edges → 00:03, running=1, and no tick fires right after reset.
- **Wrap:** preset 59:58 via adjust, then apply 2 count edges → 59:59, then 00:00.
- **Adjust seconds:** adj=1, sel=1, starting from 00:59, apply 1 adj edge → 00:00 (no carry). While adj=1, counter_clk edges leave the value unchanged.
- **Pause collision:** a pause edge and a count edge in the same cycle from 00:10 running → 00:11 and running=0. A further count edge → still 00:11.
- **Async reset mid-run:** assert rst at 12:34 between clk edges → outputs read 00:00 before the next clk edge.
- **Lap (STOPWATCH_LAP_EN):** lap edge at 00:05, then 3 count edges → outputs 00:05. A second lap edge → 00:08.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the minutes:seconds stopwatch.
// Used by stopwatch_core and bcd_mod60_inc.
package stopwatch_pkg;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    localparam bcd_pair_t BCD_ZERO = '{tens: 4'd0, ones: 4'd0};

    function automatic bcd_pair_t to_bcd(input int unsigned value);
        bcd_pair_t pair;
        pair.tens = 4'(value / 10);
        pair.ones = 4'(value % 10);
        return pair;
    endfunction

endpackage

// File: rtl/bcd_mod60_inc.sv
// Combinational BCD pair incrementer that wraps at MAX_VAL (59 by default).
// carry is 1 only when an enabled increment wraps MAX_VAL back to 00.
module bcd_mod60_inc
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_VAL = SEC_MAX
) (
    input  bcd_pair_t cur,
    input  logic      en,
    output bcd_pair_t nxt,
    output logic      carry
);

    localparam bcd_pair_t MAX_PAIR = to_bcd(MAX_VAL);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        nxt   = cur;
        carry = 1'b0;
        if (en) begin
            if (cur == MAX_PAIR) begin
                nxt   = BCD_ZERO;
                carry = 1'b1;
            end else if (cur.ones == 4'd9) begin
                nxt.ones = 4'd0;
                nxt.tens = cur.tens + 4'd1;
            end else begin
                nxt.ones = cur.ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Minutes:seconds stopwatch: edge-detects divider levels, counts 00:00..59:59, pause and adjust.
// Define STOPWATCH_LAP_EN to add the lap input that freezes the displayed digits.
module stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       counter_clk,
    input  logic       adj_clk,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
);

    logic      counter_prev_q, counter_prev_d;
    logic      adj_prev_q, adj_prev_d;
    logic      pause_prev_q, pause_prev_d;
    logic      paused_q, paused_d;
    logic      running_q, running_d;
    bcd_pair_t sec_q, sec_d;
    bcd_pair_t min_q, min_d;
    bcd_pair_t disp_sec_q, disp_sec_d;
    bcd_pair_t disp_min_q, disp_min_d;

    logic      count_tick, adj_tick, pause_tick;
    logic      sec_en, min_en, sec_carry, min_carry;
    bcd_pair_t sec_next, min_next;

    assign count_tick = counter_clk & ~counter_prev_q;
    assign adj_tick   = adj_clk & ~adj_prev_q;
    assign pause_tick = pause & ~pause_prev_q;

    // Adjust bumps one field with no carry; counting carries seconds into minutes.
    assign sec_en = adj ? (adj_tick & sel)  : (count_tick & ~paused_q);
    assign min_en = adj ? (adj_tick & ~sel) : sec_carry;

    bcd_mod60_inc #(.MAX_VAL(SEC_MAX)) u_sec_inc (
        .cur   (sec_q),
        .en    (sec_en),
        .nxt   (sec_next),
        .carry (sec_carry)
    );

    bcd_mod60_inc #(.MAX_VAL(MIN_MAX)) u_min_inc (
        .cur   (min_q),
        .en    (min_en),
        .nxt   (min_next),
        .carry (min_carry)
    );

`ifdef STOPWATCH_LAP_EN
    logic lap_prev_q, lap_prev_d;
    logic lap_hold_q, lap_hold_d;
    logic lap_tick;

    assign lap_tick = lap & ~lap_prev_q;
`endif

    always_comb begin
        counter_prev_d = counter_clk;
        adj_prev_d     = adj_clk;
        pause_prev_d   = pause;
        sec_d          = sec_next;
        min_d          = min_next;
        paused_d       = paused_q ^ pause_tick;
        running_d      = ~paused_q;
        disp_sec_d     = sec_q;
        disp_min_d     = min_q;
`ifdef STOPWATCH_LAP_EN
        lap_prev_d = lap;
        lap_hold_d = lap_hold_q ^ lap_tick;
        // The display keeps its captured value while lap_hold is set.
        if (lap_hold_q) begin
            disp_sec_d = disp_sec_q;
            disp_min_d = disp_min_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Divider levels come up high, so these histories start at 1 to block a false tick.
            counter_prev_q <= 1'b1;
            adj_prev_q     <= 1'b1;
            pause_prev_q   <= 1'b0;
            paused_q       <= 1'b0;
            running_q      <= 1'b1;
            sec_q          <= BCD_ZERO;
            min_q          <= BCD_ZERO;
            disp_sec_q     <= BCD_ZERO;
            disp_min_q     <= BCD_ZERO;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            counter_prev_q <= counter_prev_d;
            adj_prev_q     <= adj_prev_d;
            pause_prev_q   <= pause_prev_d;
            paused_q       <= paused_d;
            running_q      <= running_d;
            sec_q          <= sec_d;
            min_q          <= min_d;
            disp_sec_q     <= disp_sec_d;
            disp_min_q     <= disp_min_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_prev_q <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            lap_prev_q <= lap_prev_d;
            lap_hold_q <= lap_hold_d;
        end
    end
`endif

    assign min_tens = disp_min_q.tens;
    assign min_ones = disp_min_q.ones;
    assign sec_tens = disp_sec_q.tens;
    assign sec_ones = disp_sec_q.ones;
    assign running  = running_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus randomized traffic
// compared against a seconds-counting reference model.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       counter_clk = 1'b1;
    logic       adj_clk = 1'b1;
    logic       pause = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;

    int checks = 0;
    int errors = 0;

    // Reference model: live count and displayed count as total seconds.
    int m_live, m_disp;
    bit m_paused, m_run, m_lap_hold;
    bit m_cprev, m_aprev, m_pprev, m_lprev;

    stopwatch_core dut (
        .clk         (clk),
        .rst         (rst),
        .counter_clk (counter_clk),
        .adj_clk     (adj_clk),
        .pause       (pause),
        .adj         (adj),
        .sel         (sel),
`ifdef STOPWATCH_LAP_EN
        .lap         (lap),
`endif
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%05h exp=%05h (mm:ss:run packed)", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int mm, input int ss, input bit run);
        return {15'd0, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run};
    endfunction

    function automatic logic [31:0] dut_word();
        return {15'd0, min_tens, min_ones, sec_tens, sec_ones, running};
    endfunction

    function automatic logic [31:0] model_word();
        return pack(m_disp / 60, m_disp % 60, m_run);
    endfunction

    task automatic model_reset();
        m_live     = 0;
        m_disp     = 0;
        m_paused   = 1'b0;
        m_run      = 1'b1;
        m_lap_hold = 1'b0;
        m_cprev    = 1'b1;
        m_aprev    = 1'b1;
        m_pprev    = 1'b0;
        m_lprev    = 1'b0;
    endtask

    // One clock: update the model at the rising edge, return at the falling edge.
    task automatic cyc();
        bit ct, at, pt, lt;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            ct = counter_clk && !m_cprev;
            at = adj_clk && !m_aprev;
            pt = pause && !m_pprev;
            lt = 1'b0;
`ifdef STOPWATCH_LAP_EN
            lt = lap && !m_lprev;
`endif
            if (!m_lap_hold) m_disp = m_live;
            m_run = !m_paused;
            if (!adj) begin
                if (ct && !m_paused) m_live = (m_live + 1) % 3600;
            end else if (at) begin
                if (sel) m_live = (m_live / 60) * 60 + (m_live % 60 + 1) % 60;
                else     m_live = ((m_live / 60 + 1) % 60) * 60 + m_live % 60;
            end
            if (pt) m_paused = !m_paused;
            if (lt) m_lap_hold = !m_lap_hold;
            m_cprev = counter_clk;
            m_aprev = adj_clk;
            m_pprev = pause;
            m_lprev = lap;
        end
        @(negedge clk);
    endtask

    task automatic pulse_count();
        counter_clk = 1'b1; cyc();
        counter_clk = 1'b0; cyc();
    endtask

    task automatic pulse_adj();
        adj_clk = 1'b1; cyc();
        adj_clk = 1'b0; cyc();
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cyc();
        pause = 1'b0; cyc();
    endtask

    task automatic pulse_lap();
        lap = 1'b1; cyc();
        lap = 1'b0; cyc();
    endtask

    task automatic do_reset();
        counter_clk = 1'b0;
        adj_clk     = 1'b0;
        pause       = 1'b0;
        adj         = 1'b0;
        lap         = 1'b0;
        rst         = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic adjust_to(input int mm, input int ss);
        adj = 1'b1;
        sel = 1'b0;
        repeat (mm) pulse_adj();
        sel = 1'b1;
        repeat (ss) pulse_adj();
        adj = 1'b0;
        cyc();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        cyc();
        check("reset_state", dut_word(), pack(0, 0, 1'b1));

        // Levels high at release: no tick may fire after reset.
        rst = 1'b1;
        cyc();
        cyc();
        check("no_tick_after_reset", dut_word(), pack(0, 0, 1'b1));
        counter_clk = 1'b0;
        cyc();
        repeat (3) pulse_count();
        check("count_3", dut_word(), pack(0, 3, 1'b1));

        // Long high level still gives exactly one tick.
        counter_clk = 1'b1;
        repeat (6) cyc();
        counter_clk = 1'b0;
        cyc();
        check("one_tick_per_edge", dut_word(), pack(0, 4, 1'b1));

        do_reset();
        adjust_to(59, 58);
        check("preset_59_58", dut_word(), pack(59, 58, 1'b1));
        pulse_count();
        check("wrap_59_59", dut_word(), pack(59, 59, 1'b1));
        pulse_count();
        check("wrap_00_00", dut_word(), pack(0, 0, 1'b1));

        do_reset();
        adjust_to(0, 59);
        check("preset_00_59", dut_word(), pack(0, 59, 1'b1));
        adj = 1'b1;
        sel = 1'b1;
        pulse_adj();
        check("adj_sec_no_carry", dut_word(), pack(0, 0, 1'b1));
        sel = 1'b0;
        pulse_adj();
        check("adj_min", dut_word(), pack(1, 0, 1'b1));
        repeat (2) pulse_count();
        check("count_ignored_in_adj", dut_word(), pack(1, 0, 1'b1));
        adj = 1'b0;
        cyc();

        do_reset();
        adjust_to(0, 10);
        pause       = 1'b1;
        counter_clk = 1'b1;
        cyc();
        pause       = 1'b0;
        counter_clk = 1'b0;
        cyc();
        check("pause_collision", dut_word(), pack(0, 11, 1'b0));
        pulse_count();
        check("paused_holds", dut_word(), pack(0, 11, 1'b0));
        adj = 1'b1;
        sel = 1'b1;
        pulse_adj();
        check("adj_while_paused", dut_word(), pack(0, 12, 1'b0));
        adj = 1'b0;
        pulse_pause();
        check("resume", dut_word(), pack(0, 12, 1'b1));

        do_reset();
        adjust_to(12, 34);
        check("preset_12_34", dut_word(), pack(12, 34, 1'b1));
        #1 rst = 1'b0;
        #1 check("async_reset", dut_word(), pack(0, 0, 1'b1));
        @(negedge clk);
        cyc();
        rst = 1'b1;
        cyc();
        check("after_async_reset", dut_word(), pack(0, 0, 1'b1));

`ifdef STOPWATCH_LAP_EN
        do_reset();
        repeat (5) pulse_count();
        pulse_lap();
        repeat (3) pulse_count();
        check("lap_frozen", dut_word(), pack(0, 5, 1'b1));
        pulse_lap();
        check("lap_released", dut_word(), pack(0, 8, 1'b1));
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(399) != 0);
            if ($urandom_range(2) == 0)  counter_clk = ~counter_clk;
            if ($urandom_range(2) == 0)  adj_clk = ~adj_clk;
            if ($urandom_range(15) == 0) pause = ~pause;
            if ($urandom_range(31) == 0) adj = ~adj;
            if ($urandom_range(3) == 0)  sel = ~sel;
            if ($urandom_range(15) == 0) lap = ~lap;
            cyc();
            check("random", dut_word(), model_word());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
